// File: rtl/writeback_arbiter.sv
// Write-back arbiter: merges buffered ALU results and priority load returns onto the register file write port.
// Load -> write one edge after acceptance; ALU -> two edges minimum; alu_ready drops when the FIFO is full, mem_ready drops for one cycle when a starved FIFO head is forced through.
module writeback_arbiter #(
  parameter int DEPTH      = 4,
  parameter int STARVE_MAX = 3
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     alu_valid,
  input  logic [3:0]               alu_addr,
  input  logic [15:0]              alu_data,
  output logic                     alu_ready,
  input  logic                     mem_valid,
  input  logic [3:0]               mem_addr,
  input  logic [15:0]              mem_data,
  output logic                     mem_ready,
  output logic                     w_en,
  output logic [3:0]               addr_c,
  output logic [15:0]              data_c,
  input  logic [3:0]               query_addr,
  output logic                     pending_hit,
  output logic [$clog2(DEPTH):0]   fifo_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef struct packed {
    logic [3:0]  addr;
    logic [15:0] data;
  } wb_entry_t;

  wb_entry_t       fifo_q [DEPTH];
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic [3:0]      starve_q, starve_d;
  logic            w_en_q, w_en_d;
  logic [3:0]      addr_c_q, addr_c_d;
  logic [15:0]     data_c_q, data_c_d;

  logic            fifo_empty;
  logic            force_head;
  logic            mem_win;
  logic            enq;
  logic            deq;
  wb_entry_t       head;
  logic [DEPTH-1:0] entry_hit;

  assign fifo_empty = (count_q == '0);
  assign alu_ready  = (count_q != CW'(DEPTH));
  assign force_head = !fifo_empty && (starve_q == 4'(STARVE_MAX));
  assign mem_ready  = !force_head;
  assign mem_win    = mem_valid && mem_ready;
  assign enq        = alu_valid && alu_ready;
  assign deq        = !mem_win && !fifo_empty;
  assign head       = fifo_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q + CW'(enq) - CW'(deq);
    starve_d = starve_q;
    w_en_d   = 1'b0;
    addr_c_d = addr_c_q;
    data_c_d = data_c_q;

    if (enq) wr_ptr_d = wr_ptr_q + PW'(1);
    if (deq) rd_ptr_d = rd_ptr_q + PW'(1);

    // The head only accumulates starvation while it is present and loses.
    if (fifo_empty || deq) begin
      starve_d = '0;
    end else if (starve_q != 4'(STARVE_MAX)) begin
      starve_d = starve_q + 4'd1;
    end

    if (mem_win) begin
      w_en_d   = 1'b1;
      addr_c_d = mem_addr;
      data_c_d = mem_data;
    end else if (deq) begin
      w_en_d   = 1'b1;
      addr_c_d = head.addr;
      data_c_d = head.data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      starve_q <= '0;
      w_en_q   <= 1'b0;
      addr_c_q <= '0;
      data_c_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      starve_q <= starve_d;
      w_en_q   <= w_en_d;
      addr_c_q <= addr_c_d;
      data_c_q <= data_c_d;
    end
  end

  // Storage needs no reset: occupancy alone decides which slots are live.
  always_ff @(posedge clk) begin
    if (enq) fifo_q[wr_ptr_q] <= '{addr: alu_addr, data: alu_data};
  end

  for (genvar g = 0; g < DEPTH; g++) begin : g_hit
    logic [PW-1:0] offs;
    assign offs         = PW'(g) - rd_ptr_q;
    assign entry_hit[g] = ({1'b0, offs} < count_q) && (fifo_q[g].addr == query_addr);
  end

  assign pending_hit = (|entry_hit)
                     || (w_en_q && (addr_c_q == query_addr))
                     || (mem_win && (mem_addr == query_addr))
                     || (enq && (alu_addr == query_addr));

  assign w_en       = w_en_q;
  assign addr_c     = addr_c_q;
  assign data_c     = data_c_q;
  assign fifo_count = count_q;

endmodule

// File: tb/tb_writeback_arbiter.sv
// Directed bench: expected register-file writes queued by stimulus, popped and compared by a negedge monitor.
module tb_writeback_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        alu_valid;
  logic [3:0]  alu_addr;
  logic [15:0] alu_data;
  logic        alu_ready;
  logic        mem_valid;
  logic [3:0]  mem_addr;
  logic [15:0] mem_data;
  logic        mem_ready;
  logic        w_en;
  logic [3:0]  addr_c;
  logic [15:0] data_c;
  logic [3:0]  query_addr;
  logic        pending_hit;
  logic [2:0]  fifo_count;

  typedef struct {
    logic [3:0]  a;
    logic [15:0] d;
  } exp_t;

  exp_t sb[$];
  int   vectors     = 0;
  int   miscompares = 0;

  writeback_arbiter #(.DEPTH(4), .STARVE_MAX(3)) dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_addr(alu_addr), .alu_data(alu_data), .alu_ready(alu_ready),
    .mem_valid(mem_valid), .mem_addr(mem_addr), .mem_data(mem_data), .mem_ready(mem_ready),
    .w_en(w_en), .addr_c(addr_c), .data_c(data_c),
    .query_addr(query_addr), .pending_hit(pending_hit), .fifo_count(fifo_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [3:0] a, input logic [15:0] d);
    exp_t e;
    e.a = a;
    e.d = d;
    sb.push_back(e);
  endtask

  always @(negedge clk) begin
    if (w_en === 1'b1) begin
      if (sb.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h, expected no write", addr_c, data_c);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("wb_addr", addr_c, e.a);
        chk("wb_data", data_c, e.d);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int ai, mi;
    logic aacc, macc;

    rst = 1'b0; alu_valid = 0; alu_addr = 0; alu_data = 0;
    mem_valid = 0; mem_addr = 0; mem_data = 0; query_addr = 0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    chk("rst_w_en", w_en, 0);
    chk("rst_addr_c", addr_c, 0);
    chk("rst_data_c", data_c, 0);
    chk("rst_count", fifo_count, 0);
    chk("rst_alu_ready", alu_ready, 1);
    chk("rst_mem_ready", mem_ready, 1);

    // ALU only
    alu_valid = 1; alu_addr = 4'd3; alu_data = 16'h1234;
    #1 chk("t1_alu_ready", alu_ready, 1);
    push(4'd3, 16'h1234);
    tick();
    alu_valid = 0;
    chk("t1_count", fifo_count, 1);
    chk("t1_w_en_early", w_en, 0);
    tick();
    chk("t1_w_en", w_en, 1);
    chk("t1_addr_c", addr_c, 3);
    chk("t1_data_c", data_c, 16'h1234);
    tick();
    chk("t1_w_en_off", w_en, 0);

    // Load priority over queued ALU result
    alu_valid = 1; alu_addr = 4'd5; alu_data = 16'hAAAA;
    tick();
    alu_valid = 0;
    mem_valid = 1; mem_addr = 4'd7; mem_data = 16'h5555;
    #1 chk("t2_mem_ready", mem_ready, 1);
    push(4'd7, 16'h5555);
    push(4'd5, 16'hAAAA);
    tick();
    mem_valid = 0;
    chk("t2_first_addr", addr_c, 7);
    chk("t2_head_held", fifo_count, 1);
    tick();
    chk("t2_second_addr", addr_c, 5);
    repeat (2) tick();

    // Starvation guard
    alu_valid = 1; alu_addr = 4'd2; alu_data = 16'h0002;
    tick();
    alu_valid = 0;
    for (int j = 0; j < 3; j++) begin
      mem_valid = 1; mem_addr = 4'(8 + j); mem_data = 16'h0101 * 16'(j + 1);
      #1 chk("t3_mem_ready_lose", mem_ready, 1);
      push(4'(8 + j), 16'h0101 * 16'(j + 1));
      tick();
    end
    mem_addr = 4'd11; mem_data = 16'h0404;
    #1 chk("t3_forced", mem_ready, 0);
    push(4'd2, 16'h0002);
    tick();
    chk("t3_forced_addr", addr_c, 2);
    chk("t3_count", fifo_count, 0);
    chk("t3_mem_ready_back", mem_ready, 1);
    push(4'd11, 16'h0404);
    tick();
    mem_valid = 0;
    repeat (2) tick();

    // Full FIFO with loads always offered
    for (int j = 0; j < 4; j++) push(4'd6, 16'hB000 + 16'(j));
    push(4'hC, 16'hA001);
    push(4'd6, 16'hB004);
    push(4'hD, 16'hA002);
    push(4'hE, 16'hA003);
    push(4'hF, 16'hA004);
    push(4'h0, 16'hA005);
    ai = 0; mi = 0;
    for (int k = 0; k < 20; k++) begin
      if (ai == 5 && mi == 5) break;
      alu_valid = (ai < 5); alu_addr = 4'hC + 4'(ai); alu_data = 16'hA001 + 16'(ai);
      mem_valid = (mi < 5); mem_addr = 4'd6;         mem_data = 16'hB000 + 16'(mi);
      #1;
      if (k == 4) begin
        chk("t4_count_full", fifo_count, 4);
        chk("t4_alu_ready_full", alu_ready, 0);
        chk("t4_mem_ready_forced", mem_ready, 0);
      end
      aacc = alu_valid && alu_ready;
      macc = mem_valid && mem_ready;
      tick();
      if (aacc) ai++;
      if (macc) mi++;
    end
    chk("t4_alu_all_accepted", ai, 5);
    chk("t4_mem_all_accepted", mi, 5);
    alu_valid = 0; mem_valid = 0;
    repeat (6) tick();

    // Hazard lookup
    alu_valid = 1; alu_addr = 4'd4; alu_data = 16'h4444;
    push(4'd4, 16'h4444);
    tick();
    alu_addr = 4'd9; alu_data = 16'h9999;
    push(4'd9, 16'h9999);
    tick();
    alu_valid = 0;
    query_addr = 4'd9; #1 chk("t5_hit_fifo", pending_hit, 1);
    query_addr = 4'd4; #1 chk("t5_hit_outreg", pending_hit, 1);
    query_addr = 4'd1; #1 chk("t5_miss", pending_hit, 0);
    tick();
    query_addr = 4'd4; #1 chk("t5_outreg_moved", pending_hit, 0);
    tick();
    chk("t5_w_en_off", w_en, 0);
    query_addr = 4'd9; #1 chk("t5_committed", pending_hit, 0);
    mem_valid = 1; mem_addr = 4'd13; mem_data = 16'h1313;
    alu_valid = 1; alu_addr = 4'd14; alu_data = 16'h1414;
    query_addr = 4'd13; #1 chk("t5_hit_mem_in", pending_hit, 1);
    query_addr = 4'd14; #1 chk("t5_hit_alu_in", pending_hit, 1);
    push(4'd13, 16'h1313);
    push(4'd14, 16'h1414);
    tick();
    mem_valid = 0; alu_valid = 0;
    repeat (3) tick();

    // Mid-stream reset
    for (int k = 0; k < 3; k++) begin
      alu_valid = 1; alu_addr = 4'(1 + k); alu_data = 16'hC000 + 16'(k);
      mem_valid = 1; mem_addr = 4'hA;      mem_data = 16'hD000 + 16'(k);
      push(4'hA, 16'hD000 + 16'(k));
      tick();
    end
    alu_valid = 0; mem_valid = 0;
    chk("t6_count_pre", fifo_count, 3);
    chk("t6_w_en_pre", w_en, 1);
    rst = 1'b0;
    tick();
    rst = 1'b1;
    chk("t6_w_en", w_en, 0);
    chk("t6_count", fifo_count, 0);
    for (int q = 0; q < 16; q++) begin
      query_addr = 4'(q);
      #1 chk("t6_no_pending", pending_hit, 0);
    end
    repeat (8) tick();
    chk("sb_drained", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
